// File: rtl/flappy_pkg.sv
// Shared encodings and coordinate sizing for the pipe scheduler.
package flappy_pkg;

   localparam int XW           = 10;
   localparam int SCREEN_W_DEF = 640;
   localparam int BIRD_X_DEF   = 160;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_scheduler_if.sv
// Game-side bus of the pipe scheduler: control pulses, random input, slot outputs.
interface pipe_scheduler_if
   import flappy_pkg::*;
#(
   parameter int N_SLOTS = 4
);
   logic                    tick;
   logic                    start;
   logic                    halt;
   logic                    clear;
   logic [XW-1:0]           rand_num;
   logic [N_SLOTS*XW-1:0]   pipe_x;
   logic [N_SLOTS*XW-1:0]   pipe_gap;
   logic [N_SLOTS-1:0]      pipe_valid;
   logic                    score_pulse;
   logic                    spawn_drop;
   logic [1:0]              state;

   modport master (
      output tick, start, halt, clear, rand_num,
      input  pipe_x, pipe_gap, pipe_valid, score_pulse, spawn_drop, state
   );

   modport slave (
      input  tick, start, halt, clear, rand_num,
      output pipe_x, pipe_gap, pipe_valid, score_pulse, spawn_drop, state
   );
endinterface

// File: rtl/pipe_scheduler_slot.sv
// One pipe obstacle: x position, gap-top y and occupancy, scrolled on tick_en.
module pipe_slot
   import flappy_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int BIRD_X   = BIRD_X_DEF,
   parameter int SCROLL   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick_en,
   input  logic          load,
   input  logic [XW-1:0] load_gap,
   input  logic          clr,
   output logic [XW-1:0] x,
   output logic [XW-1:0] gap,
   output logic          valid,
   output logic          retiring,
   output logic          crossed
);

   logic [XW-1:0] x_q, x_d, gap_q, gap_d, x_mv;
   logic          valid_q, valid_d;

   assign x_mv     = x_q - XW'(SCROLL);
   assign retiring = valid_q && (x_q < XW'(SCROLL));
   // a retiring pipe keeps its x, so it can never count as a crossing
   assign crossed  = valid_q && !retiring && (x_q >= XW'(BIRD_X)) && (x_mv < XW'(BIRD_X));

   always_comb begin
      x_d     = x_q;
      gap_d   = gap_q;
      valid_d = valid_q;
      if (clr) begin
         x_d     = '0;
         gap_d   = '0;
         valid_d = 1'b0;
      end else if (load) begin
         x_d     = XW'(SCREEN_W);
         gap_d   = load_gap;
         valid_d = 1'b1;
      end else if (tick_en && valid_q) begin
         if (retiring) valid_d = 1'b0;
         else          x_d     = x_mv;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         gap_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
      end
   end

   assign x     = x_q;
   assign gap   = gap_q;
   assign valid = valid_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe pool sequencer: spawns, scrolls and retires obstacles once per frame tick.
// Optional build macro PIPE_SCHED_DIFFICULTY_EN shortens the spawn interval every 8 scores.
//
// state     | meaning
// ST_IDLE   | slots empty, waiting for start; tick ignored
// ST_RUN    | each tick scrolls slots, runs the spawn counter
// ST_FREEZE | game over, everything holds until clear
module pipe_scheduler
   import flappy_pkg::*;
#(
   parameter int N_SLOTS   = 4,
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int BIRD_X    = BIRD_X_DEF,
   parameter int SCROLL    = 2,
   parameter int SPAWN_INT = 90,
   parameter int GAP_MIN   = 40
) (
   input  logic            clk,
   input  logic            rst_n,
   pipe_scheduler_if.slave bus
);

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d, intv;
   logic                   drop_q, drop_d, score_q, score_d;
   logic                   upd, spawn_now, found;
   logic [N_SLOTS-1:0]     valid_w, retiring_w, crossed_w, free_w, load_w;
   logic [N_SLOTS*XW-1:0]  x_pk, gap_pk;
   logic [XW-1:0]          new_gap;

   assign upd       = (state_q == ST_RUN) && bus.tick && !bus.clear;
   assign spawn_now = upd && (cnt_q == 8'd0);
   assign free_w    = ~valid_w | retiring_w;
   assign new_gap   = bus.rand_num + XW'(GAP_MIN);

   for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
      pipe_slot #(
         .SCREEN_W (SCREEN_W),
         .BIRD_X   (BIRD_X),
         .SCROLL   (SCROLL)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick_en  (upd),
         .load     (load_w[i]),
         .load_gap (new_gap),
         .clr      (bus.clear),
         .x        (x_pk[i*XW +: XW]),
         .gap      (gap_pk[i*XW +: XW]),
         .valid    (valid_w[i]),
         .retiring (retiring_w[i]),
         .crossed  (crossed_w[i])
      );
   end

   always_comb begin
      load_w = '0;
      found  = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (spawn_now && free_w[i] && !found) begin
            load_w[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign score_d = upd && (|crossed_w);
   assign drop_d  = bus.clear ? 1'b0 : (drop_q | (spawn_now && !(|free_w)));

`ifdef PIPE_SCHED_DIFFICULTY_EN
   localparam int INT_FLOOR = SPAWN_INT / 2;
   logic [7:0] intv_q, intv_d;
   logic [2:0] pass_q, pass_d;

   always_comb begin
      intv_d = intv_q;
      pass_d = pass_q;
      if (bus.clear) begin
         intv_d = 8'(SPAWN_INT);
         pass_d = '0;
      end else if (score_d) begin
         pass_d = pass_q + 3'd1;
         if (pass_q == 3'd7)
            intv_d = (intv_q < 8'(INT_FLOOR + 4)) ? 8'(INT_FLOOR) : intv_q - 8'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         intv_q <= 8'(SPAWN_INT);
         pass_q <= '0;
      end else begin
         intv_q <= intv_d;
         pass_q <= pass_d;
      end
   end

   assign intv = intv_q;
`else
   assign intv = 8'(SPAWN_INT);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d = ST_RUN;
                  cnt_d   = intv - 8'd1;
               end
            end
            ST_RUN: begin
               if (bus.tick) cnt_d = (cnt_q == 8'd0) ? intv - 8'd1 : cnt_q - 8'd1;
               if (bus.halt) state_d = ST_FREEZE;
            end
            ST_FREEZE: state_d = ST_FREEZE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
         score_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         score_q <= score_d;
      end
   end

   assign bus.pipe_x      = x_pk;
   assign bus.pipe_gap    = gap_pk;
   assign bus.pipe_valid  = valid_w;
   assign bus.score_pulse = score_q;
   assign bus.spawn_drop  = drop_q;
   assign bus.state       = state_q;

endmodule
